addern_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational N-bit ripple adder.
- Splits a WIDTH-bit add/subtract into STAGES equal carry-chain slices, with one register bank per slice, and carries the skewed upper operand bits forward.
- Uses a valid/ready handshake on both sides, so it can sit between buffering blocks (e.g. FIFOs) in the datapath.
- Adds a subtract mode and a signed-overflow flag, neither of which the combinational adder has.

---
 rtl/addern_pipe.sv | 116 +++++++++++
 tb/tb_addern_pipe.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addern_pipe.sv
// Pipelined WIDTH-bit add/subtract: STAGES carry-chain slices, valid/ready on both sides.
// Upper operand slices ride along with each beat until their stage adds them.
module addern_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SW = WIDTH / STAGES;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ld;

    // Ready chain flattened: a stage may load when it or any stage after it is empty,
    // or when the sink takes the output this cycle.
    always_comb begin
        ld = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            ld[i] = out_ready || (((~vld) >> i) != '0);
        end
    end

    assign in_ready = ld[0] && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM  = WIDTH - k * SW;
        localparam int DONE = (k + 1) * SW;

        logic            v_in;
        logic            c_in;
        logic            am_in;
        logic            bm_in;
        logic [REM-1:0]  a_in;
        logic [REM-1:0]  b_in;
        logic [DONE-1:0] s_next;
        logic [SW:0]     slice;

        logic            v_q;
        logic            c_q;
        logic            am_q;
        logic            bm_q;
        logic [DONE-1:0] s_q;

        assign slice = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

        if (k == 0) begin : g_head
            assign v_in   = in_valid;
            assign a_in   = a;
            assign b_in   = sub ? ~b : b;
            assign c_in   = sub | cin;
            assign am_in  = a[WIDTH-1];
            assign bm_in  = b_in[REM-1];
            assign s_next = slice[SW-1:0];
        end else begin : g_body
            assign v_in   = g_stage[k-1].v_q;
            assign a_in   = g_stage[k-1].g_fwd.a_q;
            assign b_in   = g_stage[k-1].g_fwd.b_q;
            assign c_in   = g_stage[k-1].c_q;
            assign am_in  = g_stage[k-1].am_q;
            assign bm_in  = g_stage[k-1].bm_q;
            assign s_next = {slice[SW-1:0], g_stage[k-1].s_q};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q  <= 1'b0;
                c_q  <= 1'b0;
                am_q <= 1'b0;
                bm_q <= 1'b0;
                s_q  <= '0;
            end else if (ld[k]) begin
                v_q  <= v_in;
                c_q  <= slice[SW];
                am_q <= am_in;
                bm_q <= bm_in;
                s_q  <= s_next;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-SW-1:0] a_q;
            logic [REM-SW-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (ld[k]) begin
                    a_q <= a_in[REM-1:SW];
                    b_q <= b_in[REM-1:SW];
                end
            end
        end

        assign vld[k] = v_q;
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = (g_stage[STAGES-1].am_q == g_stage[STAGES-1].bm_q) &&
                       (sum[WIDTH-1] != g_stage[STAGES-1].am_q);

endmodule

// File: tb/tb_addern_pipe.sv
// Bench for addern_pipe: directed add/sub, throughput, backpressure, async reset,
// and random traffic over several WIDTH/STAGES configurations against an arithmetic model.
module tb_addern_pipe;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    logic [3:0]  sw_iv = '0;
    logic [3:0]  sw_ir;
    logic [3:0]  sw_cin = '0;
    logic [3:0]  sw_sub = '0;
    logic [3:0]  sw_ov;
    logic [3:0]  sw_or = '1;
    logic [3:0]  sw_cout;
    logic [3:0]  sw_ovf;
    logic [15:0] sw_a [4];
    logic [15:0] sw_b [4];
    logic [15:0] sw_sum [4];
    logic [7:0]  sum_w8s1;
    logic [7:0]  sum_w8s8;
    logic [15:0] sum_w16s4;
    logic [2:0]  sum_w3s3;

    int unsigned total = 0;
    int unsigned bad = 0;
    int          cyc = 0;
    exp_t        q[$];

    always #5 clk = ~clk;

    addern_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf));

    addern_pipe #(.WIDTH(8), .STAGES(1)) u_w8s1 (
        .clk(clk), .rst(rst), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]), .a(sw_a[0][7:0]),
        .b(sw_b[0][7:0]), .cin(sw_cin[0]), .sub(sw_sub[0]), .out_valid(sw_ov[0]),
        .out_ready(sw_or[0]), .sum(sum_w8s1), .cout(sw_cout[0]), .ovf(sw_ovf[0]));

    addern_pipe #(.WIDTH(8), .STAGES(8)) u_w8s8 (
        .clk(clk), .rst(rst), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]), .a(sw_a[1][7:0]),
        .b(sw_b[1][7:0]), .cin(sw_cin[1]), .sub(sw_sub[1]), .out_valid(sw_ov[1]),
        .out_ready(sw_or[1]), .sum(sum_w8s8), .cout(sw_cout[1]), .ovf(sw_ovf[1]));

    addern_pipe #(.WIDTH(16), .STAGES(4)) u_w16s4 (
        .clk(clk), .rst(rst), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]), .a(sw_a[2]),
        .b(sw_b[2]), .cin(sw_cin[2]), .sub(sw_sub[2]), .out_valid(sw_ov[2]),
        .out_ready(sw_or[2]), .sum(sum_w16s4), .cout(sw_cout[2]), .ovf(sw_ovf[2]));

    addern_pipe #(.WIDTH(3), .STAGES(3)) u_w3s3 (
        .clk(clk), .rst(rst), .in_valid(sw_iv[3]), .in_ready(sw_ir[3]), .a(sw_a[3][2:0]),
        .b(sw_b[3][2:0]), .cin(sw_cin[3]), .sub(sw_sub[3]), .out_valid(sw_ov[3]),
        .out_ready(sw_or[3]), .sum(sum_w3s3), .cout(sw_cout[3]), .ovf(sw_ovf[3]));

    always_comb begin
        sw_sum[0] = {8'h00, sum_w8s1};
        sw_sum[1] = {8'h00, sum_w8s8};
        sw_sum[2] = sum_w16s4;
        sw_sum[3] = {13'h0000, sum_w3s3};
    end

    // Reference: true integer arithmetic; returns {ovf, cout, sum[15:0]}.
    function automatic logic [17:0] ref_calc(input int unsigned w, input logic [15:0] av,
                                             input logic [15:0] bv, input logic ci,
                                             input logic is_sub);
        longint m, h, ua, ub, sa, sb2, t, r;
        logic   c, o;
        m   = longint'(1) << w;
        h   = m / 2;
        ua  = longint'(av) % m;
        ub  = longint'(bv) % m;
        sa  = (ua >= h) ? ua - m : ua;
        sb2 = (ub >= h) ? ub - m : ub;
        if (is_sub) begin
            t = ua - ub;
            c = (ua >= ub);
            if (t < 0) t = t + m;
            r = sa - sb2;
        end else begin
            t = ua + ub + longint'(ci);
            c = (t >= m);
            t = t % m;
            r = sa + sb2 + longint'(ci);
        end
        o = (r < -h) || (r >= h);
        return {o, c, t[15:0]};
    endfunction

    // One cycle on the main DUT: drive at negedge, report which transfers the next edge performs.
    task automatic drv(input logic iv, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input logic sb, input logic orr,
                       output logic acc, output logic pop);
        logic [17:0] r;
        exp_t        e;
        @(negedge clk);
        in_valid  = iv;
        a         = av;
        b         = bv;
        cin       = ci;
        sub       = sb;
        out_ready = orr;
        #1;
        cyc++;
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        if (acc) begin
            r     = ref_calc(8, {8'h00, av}, {8'h00, bv}, ci, sb);
            e.s   = r[15:0];
            e.c   = r[16];
            e.o   = r[17];
            e.cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic run_one(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                           input logic sb, output logic [7:0] s, output logic c,
                           output logic o, output int lat, output logic ok);
        logic acc, pop;
        int   n;
        ok = 1'b0; lat = 0; s = '0; c = 1'b0; o = 1'b0; acc = 1'b0; n = 0;
        q.delete();
        while (!acc && n < 10) begin
            drv(1'b1, av, bv, ci, sb, 1'b1, acc, pop);
            n++;
        end
        if (!acc) return;
        lat = 1;
        n   = 0;
        while (n < 10) begin
            drv(1'b0, av, bv, ci, sb, 1'b1, acc, pop);
            if (pop) begin
                s = sum; c = cout; o = ovf; ok = 1'b1;
                void'(q.pop_front());
                break;
            end
            lat++;
            n++;
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({in_ready, out_valid, sum, cout, ovf} !== 12'h000) begin
            bad++;
            $display("FAIL reset_hold got={rdy,vld,sum,c,o}=%h exp=000", {in_ready, out_valid, sum, cout, ovf});
        end
        total++;
        if (sw_ov !== 4'h0 || sw_ir !== 4'h0) begin
            bad++;
            $display("FAIL reset_sweep got ov=%h ir=%h exp=0 0", sw_ov, sw_ir);
        end
        #11 rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got rdy=%b vld=%b exp=1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        logic [7:0] ta [3] = '{8'd200, 8'd127, 8'd255};
        logic [7:0] tb [3] = '{8'd100, 8'd1, 8'd0};
        logic       tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [9:0] te [3] = '{{8'd44, 1'b1, 1'b0}, {8'd128, 1'b0, 1'b1}, {8'd0, 1'b1, 1'b0}};
        logic [7:0] s;
        logic       c, o, ok;
        int         lat;
        for (int i = 0; i < 3; i++) begin
            run_one(ta[i], tb[i], tc[i], 1'b0, s, c, o, lat, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL add_timeout[%0d] got=no result exp=result", i);
            end
            total++;
            if ({s, c, o} !== te[i]) begin
                bad++;
                $display("FAIL add_result[%0d] got={sum,c,o}=%h exp=%h", i, {s, c, o}, te[i]);
            end
            total++;
            if (lat != 2) begin
                bad++;
                $display("FAIL add_latency[%0d] got=%0d exp=2", i, lat);
            end
        end
    endtask

    task automatic test_sub();
        logic [7:0] ta [3] = '{8'd5, 8'h80, 8'd9};
        logic [7:0] tb [3] = '{8'd7, 8'd1, 8'd9};
        logic [9:0] te [3] = '{{8'd254, 1'b0, 1'b0}, {8'h7F, 1'b1, 1'b1}, {8'd0, 1'b1, 1'b0}};
        logic [7:0] s;
        logic       c, o, ok;
        int         lat;
        for (int i = 0; i < 3; i++) begin
            run_one(ta[i], tb[i], 1'b1, 1'b1, s, c, o, lat, ok);
            total++;
            if (!ok || {s, c, o} !== te[i]) begin
                bad++;
                $display("FAIL sub_result[%0d] got={sum,c,o}=%h ok=%b exp=%h", i, {s, c, o}, ok, te[i]);
            end
        end
    endtask

    task automatic test_throughput();
        logic acc, pop, iv;
        exp_t e;
        int   sent = 0;
        int   got = 0;
        q.delete();
        for (int n = 0; n < 60 && got < 21; n++) begin
            iv = (sent < 21);
            drv(iv, 8'(sent), 8'd3, 1'($urandom), sent[0], 1'b1, acc, pop);
            if (iv) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL thr_ready beat=%0d got=%b exp=1", sent, in_ready);
                end
            end
            if (acc) sent++;
            if (pop) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL thr_extra got=output exp=none");
                end else begin
                    e = q.pop_front();
                    if ({sum, cout, ovf} !== {e.s[7:0], e.c, e.o} || cyc - e.cyc != 2) begin
                        bad++;
                        $display("FAIL thr_beat[%0d] got={sum,c,o}=%h lat=%0d exp=%h lat=2",
                                 got, {sum, cout, ovf}, cyc - e.cyc, {e.s[7:0], e.c, e.o});
                    end
                end
                got++;
            end
        end
        total++;
        if (got != 21) begin
            bad++;
            $display("FAIL thr_count got=%0d exp=21", got);
        end
    endtask

    task automatic test_back_to_back_stall();
        logic       acc, pop, have;
        logic [9:0] hs;
        exp_t       e;
        int         nacc = 0;
        int         extra = 0;
        int         got = 0;
        have = 1'b0;
        hs   = '0;
        q.delete();
        for (int i = 0; i < 7; i++) begin
            drv(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, acc, pop);
            if (acc) nacc++;
            if (i >= 2) begin
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_full[%0d] got rdy=%b vld=%b exp=0 1", i, in_ready, out_valid);
                end
            end
            if (out_valid) begin
                total++;
                if (!have) begin
                    hs   = {q[0].s[7:0], q[0].c, q[0].o};
                    have = 1'b1;
                end
                if ({sum, cout, ovf} !== hs) begin
                    bad++;
                    $display("FAIL bp_frozen[%0d] got=%h exp=%h", i, {sum, cout, ovf}, hs);
                end
            end
        end
        total++;
        if (nacc != 2) begin
            bad++;
            $display("FAIL bp_accepts got=%0d exp=2", nacc);
        end
        for (int n = 0; n < 20 && got < 4; n++) begin
            drv(extra < 2, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc, pop);
            if (acc) extra++;
            if (pop) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra got=output exp=none");
                end else begin
                    e = q.pop_front();
                    if ({sum, cout, ovf} !== {e.s[7:0], e.c, e.o}) begin
                        bad++;
                        $display("FAIL bp_drain[%0d] got=%h exp=%h", got, {sum, cout, ovf}, {e.s[7:0], e.c, e.o});
                    end
                end
                got++;
            end
        end
        total++;
        if (got != 4 || q.size() != 0) begin
            bad++;
            $display("FAIL bp_count got=%0d left=%0d exp=4 0", got, q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic acc, pop;
        exp_t e;
        int   got = 0;
        q.delete();
        drv(1'b1, 8'd200, 8'd100, 1'b0, 1'b0, 1'b1, acc, pop);
        drv(1'b1, 8'd127, 8'd1, 1'b0, 1'b0, 1'b1, acc, pop);
        @(posedge clk);
        #2;
        total++;
        if (out_valid !== 1'b1 || sum !== 8'd44) begin
            bad++;
            $display("FAIL rstm_before got vld=%b sum=%0d exp=1 44", out_valid, sum);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, sum, cout, ovf} !== 12'h000) begin
            bad++;
            $display("FAIL rstm_clear got={rdy,vld,sum,c,o}=%h exp=000", {in_ready, out_valid, sum, cout, ovf});
        end
        #1 rst = 1'b0;
        q.delete();
        drv(1'b1, 8'd5, 8'd6, 1'b0, 1'b0, 1'b1, acc, pop);
        for (int n = 0; n < 6; n++) begin
            drv(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc, pop);
            if (pop) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rstm_stale got=%0d exp=none", sum);
                end else begin
                    e = q.pop_front();
                    if ({sum, cout, ovf} !== {e.s[7:0], e.c, e.o}) begin
                        bad++;
                        $display("FAIL rstm_beat got=%h exp=%h", {sum, cout, ovf}, {e.s[7:0], e.c, e.o});
                    end
                end
                got++;
            end
        end
        total++;
        if (got != 1) begin
            bad++;
            $display("FAIL rstm_count got=%0d exp=1", got);
        end
    endtask

    task automatic test_sweep(input int unsigned id, input int unsigned w);
        exp_t        sq[$];
        exp_t        e;
        logic [17:0] r, held;
        logic        hold;
        logic [15:0] mask;
        int          sent = 0;
        int          got = 0;
        mask = 16'((32'd1 << w) - 1);
        hold = 1'b0;
        held = '0;
        for (int n = 0; n < 20000 && got < 1000; n++) begin
            @(negedge clk);
            sw_iv[id]  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            sw_a[id]   = 16'($urandom) & mask;
            sw_b[id]   = 16'($urandom) & mask;
            sw_cin[id] = 1'($urandom);
            sw_sub[id] = 1'($urandom);
            sw_or[id]  = (sent >= 1000) || ($urandom_range(0, 3) != 0);
            #1;
            if (hold) begin
                total++;
                if (sw_ov[id] !== 1'b1 || {sw_ovf[id], sw_cout[id], sw_sum[id]} !== held) begin
                    bad++;
                    $display("FAIL sweep%0d_hold got=%h exp=%h", id, {sw_ovf[id], sw_cout[id], sw_sum[id]}, held);
                end
            end
            if (sw_iv[id] && sw_ir[id]) begin
                r     = ref_calc(w, sw_a[id], sw_b[id], sw_cin[id], sw_sub[id]);
                e.s   = r[15:0];
                e.c   = r[16];
                e.o   = r[17];
                e.cyc = n;
                sq.push_back(e);
                sent++;
            end
            if (sw_ov[id] && sw_or[id]) begin
                total++;
                if (sq.size() == 0) begin
                    bad++;
                    $display("FAIL sweep%0d_extra got=output exp=none", id);
                end else begin
                    e = sq.pop_front();
                    if ({sw_ovf[id], sw_cout[id], sw_sum[id]} !== {e.o, e.c, e.s}) begin
                        bad++;
                        $display("FAIL sweep%0d_beat[%0d] got=%h exp=%h", id, got,
                                 {sw_ovf[id], sw_cout[id], sw_sum[id]}, {e.o, e.c, e.s});
                    end
                end
                got++;
            end
            hold = sw_ov[id] && !sw_or[id];
            held = {sw_ovf[id], sw_cout[id], sw_sum[id]};
        end
        @(negedge clk);
        sw_iv[id] = 1'b0;
        sw_or[id] = 1'b1;
        total++;
        if (got != 1000 || sq.size() != 0) begin
            bad++;
            $display("FAIL sweep%0d_count got=%0d left=%0d exp=1000 0", id, got, sq.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            sw_a[i] = '0;
            sw_b[i] = '0;
        end
        test_reset();
        test_add();
        test_sub();
        test_throughput();
        test_back_to_back_stall();
        test_reset_midstream();
        test_sweep(0, 8);
        test_sweep(1, 8);
        test_sweep(2, 16);
        test_sweep(3, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
